// File: rtl/dct_pkg.sv
// +----------------------------------------------------------------------------+
// | dct_pkg : shared widths and FSM encoding for the DCT coefficient serializer |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package dct_pkg;
    localparam int IN_W       = 40;
    localparam int IN_FRAC    = 24;
    localparam int OUT_FRAC   = 4;
    localparam int N_COEF     = 8;
    localparam int BASE_SHIFT = IN_FRAC - OUT_FRAC;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;
endpackage

`default_nettype wire

// File: rtl/dct_coef_quant.sv
// +----------------------------------------------------------------------------+
// | dct_coef_quant : round-half-up arithmetic right shift with saturation      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dct_coef_quant
    import dct_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  value_i,
    input  logic [4:0]       shift_i,
    output logic [OUT_W-1:0] result_o,
    output logic             sat_o
);
    localparam logic signed [IN_W:0] C_MAX = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] C_MIN = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic        [IN_W:0] w_half;
    logic signed [IN_W:0] w_sum;
    logic signed [IN_W:0] w_t;

    // One guard bit keeps value + half from wrapping at the positive extreme.
    always_comb begin
        w_half   = {{IN_W{1'b0}}, 1'b1} << (shift_i - 5'd1);
        w_sum    = $signed({value_i[IN_W-1], value_i}) + $signed(w_half);
        w_t      = w_sum >>> shift_i;
        sat_o    = 1'b0;
        result_o = w_t[OUT_W-1:0];
        if (w_t > C_MAX) begin
            result_o = C_MAX[OUT_W-1:0];
            sat_o    = 1'b1;
        end else if (w_t < C_MIN) begin
            result_o = C_MIN[OUT_W-1:0];
            sat_o    = 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/dct_coef_serializer.sv
// +----------------------------------------------------------------------------+
// | dct_coef_serializer : snapshots 8 DCT outputs, streams quantised coefs     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dct_coef_serializer
    import dct_pkg::*;
#(
    parameter logic [23:0] QSHIFT = 24'h0,
    parameter int          OUT_W  = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [IN_W-1:0]  g0,
    input  logic [IN_W-1:0]  g1,
    input  logic [IN_W-1:0]  g2,
    input  logic [IN_W-1:0]  g3,
    input  logic [IN_W-1:0]  g4,
    input  logic [IN_W-1:0]  g5,
    input  logic [IN_W-1:0]  g6,
    input  logic [IN_W-1:0]  g7,
    input  logic             coef_ready,
    output logic [OUT_W-1:0] coef_out,
    output logic [2:0]       coef_idx,
    output logic             coef_valid,
    output logic             coef_last,
    output logic             busy,
    output logic             sat,
    output logic             overrun
);
    state_e           state_q, state_d;
    logic [IN_W-1:0]  snap_q [N_COEF];
    logic [IN_W-1:0]  snap_d [N_COEF];
    logic [IN_W-1:0]  w_g    [N_COEF];
    logic [2:0]       idx_q, idx_d;
    logic [OUT_W-1:0] coef_out_q;
    logic             cur_sat_q;
    logic             sat_q, sat_d;
    logic             overrun_q, overrun_d;
    logic             w_hs;
    logic             w_capture;
    logic [4:0]       w_shift;
    logic [OUT_W-1:0] w_q_result;
    logic             w_q_sat;

    assign w_g[0] = g0;
    assign w_g[1] = g1;
    assign w_g[2] = g2;
    assign w_g[3] = g3;
    assign w_g[4] = g4;
    assign w_g[5] = g5;
    assign w_g[6] = g6;
    assign w_g[7] = g7;

    assign w_hs = (state_q == ST_SEND) && coef_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        sat_d     = sat_q;
        overrun_d = overrun_q;
        w_capture = 1'b0;
        if (w_hs && cur_sat_q) begin
            sat_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    w_capture = 1'b1;
                    idx_d     = 3'd0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
                        if (load) begin
                            w_capture = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                if (load && !(w_hs && (idx_q == 3'd7))) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_capture) begin
            snap_d = w_g;
        end
    end

    // Quantise the coefficient that will be on display next cycle, so the
    // output register stays valid with one-cycle load latency and holds on stall.
    assign w_shift = 5'(BASE_SHIFT) + {2'b00, QSHIFT[3*idx_d +: 3]};

    dct_coef_quant #(
        .OUT_W (OUT_W)
    ) u_quant (
        .value_i  (snap_d[idx_d]),
        .shift_i  (w_shift),
        .result_o (w_q_result),
        .sat_o    (w_q_sat)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            coef_out_q <= '0;
            cur_sat_q  <= 1'b0;
            sat_q      <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            coef_out_q <= w_q_result;
            cur_sat_q  <= w_q_sat;
            sat_q      <= sat_d;
            overrun_q  <= overrun_d;
            snap_q     <= snap_d;
        end
    end

    assign coef_out   = coef_out_q;
    assign coef_idx   = idx_q;
    assign coef_valid = (state_q == ST_SEND);
    assign busy       = (state_q == ST_SEND);
    assign coef_last  = (state_q == ST_SEND) && (idx_q == 3'd7);
    assign sat        = sat_q;
    assign overrun    = overrun_q;
endmodule

`default_nettype wire

// File: tb/tb_dct_coef_serializer.sv
// +----------------------------------------------------------------------------+
// | tb_dct_coef_serializer : directed + random bench with a frame-queue model  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dct_coef_serializer;
    localparam logic [23:0] QS = 24'hA00000;   // coefficient 7 gets an extra shift of 5

    typedef struct {
        int idx;
        int val;
        bit sat;
    } beat_t;

    logic               clk = 1'b0;
    logic               clr = 1'b1;
    logic               load = 1'b0;
    logic               coef_ready = 1'b0;
    logic [39:0]        g [8];
    logic signed [15:0] coef_out;
    logic [2:0]         coef_idx;
    logic               coef_valid;
    logic               coef_last;
    logic               busy;
    logic               sat;
    logic               overrun;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t exp_q[$];
    bit    sat_m = 1'b0;
    bit    ovr_m = 1'b0;
    int    exp_c [7] = '{16, 1, 0, 0, -1, 32767, -32768};
    logic [39:0] saved [8];

    always #5 clk = ~clk;

    dct_coef_serializer #(
        .QSHIFT (QS),
        .OUT_W  (16)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .load       (load),
        .g0         (g[0]),
        .g1         (g[1]),
        .g2         (g[2]),
        .g3         (g[3]),
        .g4         (g[4]),
        .g5         (g[5]),
        .g6         (g[6]),
        .g7         (g[7]),
        .coef_ready (coef_ready),
        .coef_out   (coef_out),
        .coef_idx   (coef_idx),
        .coef_valid (coef_valid),
        .coef_last  (coef_last),
        .busy       (busy),
        .sat        (sat),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference quantiser: real-valued scaling rule done in 64-bit integers.
    function automatic beat_t qref(input int i, input logic [39:0] gv);
        beat_t  b;
        longint gs;
        longint t;
        int     s;
        logic [23:0] qv;
        qv    = QS;
        gs    = longint'($signed(gv));
        s     = 20 + int'(qv[3*i +: 3]);
        t     = (gs + (longint'(1) <<< (s - 1))) >>> s;
        b.idx = i;
        b.sat = 1'b0;
        if (t > 32767) begin
            t = 32767; b.sat = 1'b1;
        end else if (t < -32768) begin
            t = -32768; b.sat = 1'b1;
        end
        b.val = int'(t);
        return b;
    endfunction

    function automatic logic [39:0] rnd40();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: return r[39:0];
            1: return ($urandom_range(0, 1) != 0) ? 40'h7FFFFFFFFF : 40'h8000000000;
            2: return 40'(longint'($urandom_range(0, 4194304)) - 64'sd2097152);
            default: return {{12{r[27]}}, r[27:0]};
        endcase
    endfunction

    // Model: a frame is a queue of 8 expected beats; a load is accepted only
    // when the queue is empty after this cycle's handshake.
    always @(negedge clk) begin
        bit mv;
        mv = (exp_q.size() > 0);
        chk("valid", $signed({1'b0, coef_valid}), $signed({1'b0, mv}));
        chk("busy", $signed({1'b0, busy}), $signed({1'b0, mv}));
        chk("sat", $signed({1'b0, sat}), $signed({1'b0, sat_m}));
        chk("overrun", $signed({1'b0, overrun}), $signed({1'b0, ovr_m}));
        if (mv) begin
            chk("idx", $signed({1'b0, coef_idx}), exp_q[0].idx);
            chk("out", coef_out, exp_q[0].val);
            chk("last", $signed({1'b0, coef_last}), (exp_q[0].idx == 7) ? 1 : 0);
        end
        if (clr) begin
            exp_q.delete();
            sat_m = 1'b0;
            ovr_m = 1'b0;
        end else begin
            if (mv && coef_ready) begin
                sat_m = sat_m | exp_q[0].sat;
                void'(exp_q.pop_front());
            end
            if (load) begin
                if (exp_q.size() == 0) begin
                    for (int i = 0; i < 8; i++) exp_q.push_back(qref(i, g[i]));
                end else begin
                    ovr_m = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 8; i++) begin
            g[i]     = rnd40();
            saved[i] = g[i];
        end
    endtask

    task automatic wait_idx(input logic [2:0] want, input string tag);
        int n;
        n = 0;
        while (coef_idx != want && n < 20) begin
            tick();
            n++;
        end
        chk(tag, $signed({1'b0, coef_idx}), $signed({1'b0, want}));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_out"}, coef_out, 0);
        chk({tag, "_idx"}, $signed({1'b0, coef_idx}), 0);
        chk({tag, "_valid"}, $signed({1'b0, coef_valid}), 0);
        chk({tag, "_last"}, $signed({1'b0, coef_last}), 0);
        chk({tag, "_busy"}, $signed({1'b0, busy}), 0);
        chk({tag, "_sat"}, $signed({1'b0, sat}), 0);
        chk({tag, "_ovr"}, $signed({1'b0, overrun}), 0);
    endtask

    initial begin
        beat_t b;
        for (int i = 0; i < 8; i++) g[i] = '0;
        repeat (2) tick();
        clr = 1'b0;
        @(negedge clk);
        chk_cleared("reset");

        // Known values: unit input, rounding boundaries, saturation.
        tick();
        g = '{40'h0001000000, 40'h0000080000, 40'h000007FFFF, 40'hFFFFF80000,
              40'hFFFFF7FFFF, 40'h7FFFFFFFFF, 40'h8000000000, 40'h0000123456};
        load       = 1'b1;
        coef_ready = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t1_valid", $signed({1'b0, coef_valid}), 1);
            chk("t1_idx", $signed({1'b0, coef_idx}), k);
            chk("t1_last", $signed({1'b0, coef_last}), (k == 7) ? 1 : 0);
            if (k < 7) chk("t1_val", coef_out, exp_c[k]);
            tick();
        end
        @(negedge clk);
        chk("t3_sat_sticky", $signed({1'b0, sat}), 1);
        chk("t1_idle", $signed({1'b0, coef_valid}), 0);

        // Backpressure at index 3.
        tick();
        rand_frame();
        load = 1'b1;
        tick();
        load = 1'b0;
        wait_idx(3'd3, "t4_reach");
        coef_ready = 1'b0;
        b = qref(3, saved[3]);
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_idx", $signed({1'b0, coef_idx}), 3);
            chk("t4_hold_out", coef_out, b.val);
            tick();
        end
        coef_ready = 1'b1;
        wait_idx(3'd0, "t4_done");

        // Load mid-frame is dropped; load on the final handshake is seamless.
        rand_frame();
        load = 1'b1;
        tick();
        load = 1'b0;
        wait_idx(3'd2, "t5_reach2");
        for (int i = 0; i < 8; i++) g[i] = rnd40();
        load = 1'b1;
        tick();
        load = 1'b0;
        @(negedge clk);
        chk("t5_overrun", $signed({1'b0, overrun}), 1);
        tick();
        wait_idx(3'd7, "t5_reach7");
        rand_frame();
        load = 1'b1;
        tick();
        load = 1'b0;
        @(negedge clk);
        b = qref(0, saved[0]);
        chk("t5_b2b_valid", $signed({1'b0, coef_valid}), 1);
        chk("t5_b2b_idx", $signed({1'b0, coef_idx}), 0);
        chk("t5_b2b_out", coef_out, b.val);

        // Clear mid-frame, then restart.
        tick();
        wait_idx(3'd4, "t6_reach4");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        chk_cleared("t6_clr");
        tick();
        rand_frame();
        load = 1'b1;
        tick();
        load = 1'b0;
        @(negedge clk);
        b = qref(0, saved[0]);
        chk("t6_restart_idx", $signed({1'b0, coef_idx}), 0);
        chk("t6_restart_out", coef_out, b.val);
        tick();

        // Random traffic against the model.
        repeat (600) begin
            for (int i = 0; i < 8; i++) g[i] = rnd40();
            coef_ready = ($urandom_range(0, 3) != 0);
            load       = ($urandom_range(0, 9) == 0);
            clr        = ($urandom_range(0, 149) == 0);
            tick();
        end
        clr        = 1'b0;
        load       = 1'b0;
        coef_ready = 1'b1;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
